axis_fifo: RTL and testbench
============================

Name: axis_fifo

Overview:
- Synchronous single-clock FIFO with AXI4-Stream slave (input) and master (output) ports, data only (no tlast/tkeep).
- Decouples producer and consumer. Instances chain directly: one instance's m_axis drives the next instance's s_axis.
- Capacity is exactly DEPTH words. Output is first-word-fall-through: the head word is presented whenever the FIFO is non-empty.

Parameters:
- WIDTH, 32, tdata width in bits (>=1).
- ADDR_WIDTH, 4, pointer width. DEPTH = 2**ADDR_WIDTH = 16 entries.

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  WIDTH  input data.
- s_axis_tvalid  in  1  input data valid.
- s_axis_tready  out  1  FIFO can accept a word (not full).
- m_axis_tdata  out  WIDTH  head-of-FIFO data.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  downstream accepts the word.

Behaviour:
- Reset, asynchronous, while aresetn=0:
  - write pointer, read pointer and occupancy count = 0.
  - m_axis_tvalid=0 and s_axis_tready=0. m_axis_tdata is don't-care; drive 0.
  - Storage contents are not cleared.
- First rising edge after release: s_axis_tready=1.
- Reset mid-operation discards all contents immediately, with no partial transfer.
- Write handshake: s_axis_tvalid & s_axis_tready at a rising edge.
  - Data is stored at the write pointer; the write pointer increments modulo DEPTH.
- Read handshake: m_axis_tvalid & m_axis_tready at a rising edge.
  - The read pointer increments modulo DEPTH; the next word (if any) is presented in the following cycle.
- Pointers wrap naturally at DEPTH. Full vs empty is distinguished by the count (0..DEPTH, ADDR_WIDTH+1 bits).
- count next value:
  - +1 on write only.
  - -1 on read only.
  - unchanged on both or neither.
- Registered status flags: s_axis_tready = (count != DEPTH); m_axis_tvalid = (count != 0).
  - Both are updated at the same edge as count.
  - No combinational path from any input to any output control signal.
  - m_axis_tdata = storage[read pointer], combinational read of the storage array, or an equivalent registered head.
- Latency: a word written into an empty FIFO at edge k has m_axis_tvalid=1 and that data on m_axis_tdata immediately after edge k. It can be read at edge k+1.
- Full: s_axis_tready=0 and writes are ignored even if s_axis_tvalid=1.
  - A read while full makes s_axis_tready=1 after that edge.
  - Simultaneous write while full is not accepted (tready low).
- Empty: m_axis_tvalid=0 and m_axis_tready is ignored.
  - A simultaneous read and write is only possible when 0 < count < DEPTH; count is unchanged and data order is preserved.
- Order: strict FIFO. Data is passed unmodified; no width conversion.
- AXI rules:
  - Once m_axis_tvalid=1, m_axis_tvalid and m_axis_tdata hold until a read handshake.
  - The FIFO does not depend on upstream tvalid stability for correctness.
- Throughput: one write and one read per cycle sustained when neither full nor empty.

Test Plan:
- Reset: hold aresetn=0 for one cycle, then release -> m_axis_tvalid=0 and s_axis_tready=0 during reset; s_axis_tready=1 after the first edge post-release.
- Fill/stall: m_axis_tready=0, drive s_axis_tvalid=1 with data 1,2,3,... incrementing per handshake -> exactly 16 handshakes (data 1..16), then s_axis_tready=0 and no further acceptance. m_axis_tdata=1 with m_axis_tvalid=1 from the cycle after the first write.
- Chained pair, downstream m_axis_tready=0, push 50 words -> exactly 32 accepted (1..32), then input stalls. Then m_axis_tready=1 -> outputs 1..32 in order, one per cycle; m_axis_tvalid falls after word 32.
- Drain from full: after fill, m_axis_tready=1 for one cycle -> word 1 read, s_axis_tready=1 next cycle, count=15.
- Concurrent: count=5, s_axis_tvalid=1 and m_axis_tready=1 for 20 cycles -> 20 words out in order, count stays 5, pointers wrap past 15 correctly.
- Async reset mid-stream: assert aresetn=0 between edges with count=7 -> m_axis_tvalid=0 immediately without waiting for a clock edge; after release the FIFO is empty and the next written word (e.g. 0xDEADBEEF) is the first one out.

Source files
------------

// File: rtl/axis_fifo.sv
// AXI4-Stream single-clock FIFO with DEPTH words and first-word-fall-through output; head visible right after the write edge.
// Latency: a word written at edge k is presented after edge k. s_axis_tready is low when full or in reset; m_axis_tready is ignored when empty.
module axis_fifo #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  s_rdy_q, s_rdy_d;
    logic                  m_vld_q, m_vld_d;
    logic                  wr_en;
    logic                  rd_en;

    // Handshakes use only registered flags, so no input reaches an output control.
    assign wr_en = s_axis_tvalid & s_rdy_q;
    assign rd_en = m_vld_q & m_axis_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        s_rdy_d = (count_d != FULL_CNT);
        m_vld_d = (count_d != '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            s_rdy_q  <= s_rdy_d;
            m_vld_q  <= m_vld_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_vld_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: a queue model checks a standalone instance every cycle; a chained pair is checked with directed expectations.
module tb_axis_fifo;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic [31:0] a_sd = '0;
    logic        a_sv = 1'b0;
    logic        a_sr;
    logic [31:0] a_md;
    logic        a_mv;
    logic        a_mr = 1'b0;

    logic [31:0] b_sd = '0;
    logic        b_sv = 1'b0;
    logic        b_sr;
    logic [31:0] bc_d;
    logic        bc_v;
    logic        bc_r;
    logic [31:0] c_md;
    logic        c_mv;
    logic        c_mr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_fifo u_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(a_sd), .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
        .m_axis_tdata(a_md), .m_axis_tvalid(a_mv), .m_axis_tready(a_mr)
    );

    axis_fifo u_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
        .m_axis_tdata(bc_d), .m_axis_tvalid(bc_v), .m_axis_tready(bc_r)
    );

    axis_fifo u_c (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(bc_d), .s_axis_tvalid(bc_v), .s_axis_tready(bc_r),
        .m_axis_tdata(c_md), .m_axis_tvalid(c_mv), .m_axis_tready(c_mr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of u_a: a 16-entry queue plus a flag for "at least one edge since reset".
    logic [31:0] q[$];
    bit          op = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q.delete();
            op = 0;
        end else begin
            bit w, r;
            w = a_sv && op && (q.size() < 16);
            r = a_mr && (q.size() > 0);
            if (r) void'(q.pop_front());
            if (w) q.push_back(a_sd);
            op = 1;
        end
    end

    always @(negedge aclk) begin
        bit exp_vld, exp_rdy;
        exp_vld = (q.size() != 0);
        exp_rdy = op && (q.size() != 16);
        chk("model_tvalid", {31'd0, a_mv}, {31'd0, exp_vld});
        chk("model_tready", {31'd0, a_sr}, {31'd0, exp_rdy});
        if (exp_vld) chk("model_tdata", a_md, q[0]);
        else if (!aresetn) chk("model_tdata_rst", a_md, 32'd0);
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int d, n, first, last;
        bit hs;

        // Reset held for one cycle, then released.
        step();
        chk("rst_tvalid", {31'd0, a_mv}, 32'd0);
        chk("rst_tready", {31'd0, a_sr}, 32'd0);
        aresetn = 1'b1;
        #1;
        chk("rel_tready_before_edge", {31'd0, a_sr}, 32'd0);
        step();
        chk("rel_tready_after_edge", {31'd0, a_sr}, 32'd1);

        // Fill with downstream stalled.
        d = 1;
        a_sv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_sd = d;
            hs = a_sr;
            step();
            if (hs) begin
                if (d == 1) begin
                    chk("first_tvalid", {31'd0, a_mv}, 32'd1);
                    chk("first_tdata", a_md, 32'd1);
                end
                d++;
            end
        end
        a_sv = 1'b0;
        chk("fill_count", d - 1, 32'd16);
        chk("full_tready", {31'd0, a_sr}, 32'd0);
        chk("full_head", a_md, 32'd1);

        // One read while full.
        a_mr = 1'b1;
        step();
        a_mr = 1'b0;
        chk("drain1_tready", {31'd0, a_sr}, 32'd1);
        chk("drain1_head", a_md, 32'd2);
        chk("drain1_model_count", q.size(), 32'd15);

        // Bring occupancy to 5 (words 12..16 remain).
        a_mr = 1'b1;
        for (int i = 0; i < 10; i++) step();
        a_mr = 1'b0;
        chk("five_head", a_md, 32'd12);
        chk("five_model_count", q.size(), 32'd5);

        // Concurrent read/write for 20 cycles; pointers wrap.
        a_sv = 1'b1;
        a_mr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_sd = 100 + i;
            chk("conc_tvalid", {31'd0, a_mv}, 32'd1);
            chk("conc_tdata", a_md, (i < 5) ? 32'(12 + i) : 32'(95 + i));
            step();
        end
        a_sv = 1'b0;
        a_mr = 1'b0;
        chk("conc_model_count", q.size(), 32'd5);
        chk("conc_head_after", a_md, 32'd115);
        chk("conc_tready_after", {31'd0, a_sr}, 32'd1);

        // Occupancy 7, then asynchronous reset between edges.
        a_sv = 1'b1;
        a_sd = 200; step();
        a_sd = 201; step();
        a_sv = 1'b0;
        chk("pre_rst_model_count", q.size(), 32'd7);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", {31'd0, a_mv}, 32'd0);
        chk("async_rst_tready", {31'd0, a_sr}, 32'd0);
        step();
        aresetn = 1'b1;
        step();
        chk("post_rst_tvalid", {31'd0, a_mv}, 32'd0);
        a_sd = 32'hDEADBEEF;
        a_sv = 1'b1;
        step();
        a_sv = 1'b0;
        chk("post_rst_first_vld", {31'd0, a_mv}, 32'd1);
        chk("post_rst_first_dat", a_md, 32'hDEADBEEF);
        a_mr = 1'b1;
        step();
        a_mr = 1'b0;
        chk("post_rst_empty", {31'd0, a_mv}, 32'd0);

        // Chained pair: 32 words accepted with downstream stalled.
        d = 1;
        for (int i = 0; i < 60; i++) begin
            b_sv = (d <= 50);
            b_sd = d;
            hs = b_sr && b_sv;
            step();
            if (hs) d++;
        end
        b_sv = 1'b0;
        chk("chain_accepted", d - 1, 32'd32);
        chk("chain_in_stalled", {31'd0, b_sr}, 32'd0);

        c_mr = 1'b1;
        n = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            if (c_mv) begin
                chk("chain_out", c_md, 32'(n + 1));
                if (first < 0) first = i;
                last = i;
                n++;
            end
            step();
        end
        c_mr = 1'b0;
        chk("chain_out_count", n, 32'd32);
        chk("chain_back_to_back", last - first, 32'd31);
        chk("chain_empty_vld", {31'd0, c_mv}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
